regs_rvseed_mp: RTL and testbench

- Parametrised successor to the RVSEED integer register file.
- Configurable data width, register count and number of read ports; register 0 is hard-wired to zero.
- Adds a per-register pending-write scoreboard (busy bits) that the issue stage sets and the writeback stage clears, plus a flush to recover from pipeline kills.
- Sits between RVSEED decode/issue (read ports, busy query, issue marking) and writeback (write port).

---
 rtl/regs_rvseed_mp.sv | 124 ++++++++++++
 tb/tb_regs_rvseed_mp.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/regs_rvseed_mp.sv
// ============================================================================
// Module   : regs_rvseed_mp
// Brief    : Parametrised RVSEED integer register file with multiple
//            combinational read ports and a per-register pending-write
//            scoreboard (set at issue, cleared at writeback, flushable).
//            Optional macro REGS_RVSEED_BYPASS_EN enables same-cycle
//            write-to-read forwarding.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module regs_rvseed_mp #(
   parameter int DATA_WIDTH = 32,
   parameter int REG_NUM    = 32,
   parameter int ADDR_WIDTH = 16,
   parameter int RD_PORTS   = 2,
   parameter int ZERO_REG   = 1
) (
   input  logic                           clk_reg,
   input  logic                           rst_reg_n,
   input  logic                           reg_wen,
   input  logic [ADDR_WIDTH-1:0]          reg_waddr,
   input  logic [DATA_WIDTH-1:0]          reg_wdata,
   input  logic                           iss_valid,
   input  logic [ADDR_WIDTH-1:0]          iss_waddr,
   input  logic                           flush,
   input  logic [RD_PORTS*ADDR_WIDTH-1:0] rd_raddr,
   output logic [RD_PORTS*DATA_WIDTH-1:0] rd_rdata,
   output logic [RD_PORTS-1:0]            rd_busy,
   output logic [REG_NUM-1:0]             busy_vec
);

   localparam int C_IDX_W = (REG_NUM > 1) ? $clog2(REG_NUM) : 1;

   // Word-aligned and inside the register window.
   function automatic logic addr_ok(input logic [ADDR_WIDTH-1:0] a);
      return (a[1:0] == 2'b00) && ((a >> 2) < ADDR_WIDTH'(REG_NUM));
   endfunction

   logic [DATA_WIDTH-1:0] w_reg_q [REG_NUM];

   logic               w_wr_ok;
   logic [C_IDX_W-1:0] w_wr_idx;
   logic               w_iss_ok;
   logic [C_IDX_W-1:0] w_iss_idx;

   // A hard-wired zero register is neither writable nor issuable.
   assign w_wr_idx  = reg_waddr[C_IDX_W+1:2];
   assign w_wr_ok   = reg_wen && addr_ok(reg_waddr) &&
                      !((ZERO_REG != 0) && (w_wr_idx == '0));
   assign w_iss_idx = iss_waddr[C_IDX_W+1:2];
   assign w_iss_ok  = iss_valid && addr_ok(iss_waddr) &&
                      !((ZERO_REG != 0) && (w_iss_idx == '0));

   // ------------------------------------------------------------------------
   // Storage and scoreboard, one slice per architectural register
   // ------------------------------------------------------------------------
   for (genvar i = 0; i < REG_NUM; i++) begin : g_reg
      if ((ZERO_REG != 0) && (i == 0)) begin : g_zero
         assign w_reg_q[i]  = '0;
         assign busy_vec[i] = 1'b0;
      end else begin : g_live
         logic [DATA_WIDTH-1:0] r_data;
         logic                  r_busy;
         logic                  w_wr_hit;
         logic                  w_iss_hit;

         assign w_wr_hit  = w_wr_ok  && (w_wr_idx  == C_IDX_W'(i));
         assign w_iss_hit = w_iss_ok && (w_iss_idx == C_IDX_W'(i));

         // Data register: writeback lands regardless of flush.
         always_ff @(posedge clk_reg or negedge rst_reg_n) begin
            if (!rst_reg_n)    r_data <= '0;
            else if (w_wr_hit) r_data <= reg_wdata;
         end

         // Busy bit: flush > issue (younger writer) > writeback clear > hold.
         always_ff @(posedge clk_reg or negedge rst_reg_n) begin
            if (!rst_reg_n)     r_busy <= 1'b0;
            else if (flush)     r_busy <= 1'b0;
            else if (w_iss_hit) r_busy <= 1'b1;
            else if (w_wr_hit)  r_busy <= 1'b0;
         end

         assign w_reg_q[i]  = r_data;
         assign busy_vec[i] = r_busy;
      end
   end

   // ------------------------------------------------------------------------
   // Independent combinational read ports
   // ------------------------------------------------------------------------
   for (genvar p = 0; p < RD_PORTS; p++) begin : g_rd
      logic [ADDR_WIDTH-1:0] w_ra;
      logic                  w_ok;
      logic [C_IDX_W-1:0]    w_idx;
      logic [DATA_WIDTH-1:0] w_data_st;
      logic                  w_busy_st;

      assign w_ra      = rd_raddr[p*ADDR_WIDTH +: ADDR_WIDTH];
      assign w_ok      = addr_ok(w_ra);
      assign w_idx     = w_ra[C_IDX_W+1:2];
      assign w_data_st = w_ok ? w_reg_q[w_idx]  : '0;
      assign w_busy_st = w_ok ? busy_vec[w_idx] : 1'b0;

`ifdef REGS_RVSEED_BYPASS_EN
      logic w_fwd;

      // w_wr_ok already excludes invalid and zero-register targets.
      assign w_fwd = w_wr_ok && (reg_waddr == w_ra);

      // Forwarded data is current, so it is busy only if re-issued now.
      assign rd_rdata[p*DATA_WIDTH +: DATA_WIDTH] = w_fwd ? reg_wdata : w_data_st;
      assign rd_busy[p] = w_fwd ? (w_iss_ok && (w_iss_idx == w_idx) && !flush)
                                : w_busy_st;
`else
      assign rd_rdata[p*DATA_WIDTH +: DATA_WIDTH] = w_data_st;
      assign rd_busy[p] = w_busy_st;
`endif
   end

endmodule

`default_nettype wire

// File: tb/tb_regs_rvseed_mp.sv
// ============================================================================
// Module   : tb_regs_rvseed_mp
// Brief    : Directed self-checking bench for regs_rvseed_mp (defaults:
//            32x32, 2 read ports, zero register on).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_regs_rvseed_mp;

   localparam int DW = 32;
   localparam int RN = 32;
   localparam int AW = 16;
   localparam int RP = 2;

   logic             clk_reg;
   logic             rst_reg_n;
   logic             reg_wen;
   logic [AW-1:0]    reg_waddr;
   logic [DW-1:0]    reg_wdata;
   logic             iss_valid;
   logic [AW-1:0]    iss_waddr;
   logic             flush;
   logic [RP*AW-1:0] rd_raddr;
   logic [RP*DW-1:0] rd_rdata;
   logic [RP-1:0]    rd_busy;
   logic [RN-1:0]    busy_vec;

   int checks = 0;
   int errors = 0;

   regs_rvseed_mp #(
      .DATA_WIDTH(DW), .REG_NUM(RN), .ADDR_WIDTH(AW), .RD_PORTS(RP), .ZERO_REG(1)
   ) dut (
      .clk_reg  (clk_reg),
      .rst_reg_n(rst_reg_n),
      .reg_wen  (reg_wen),
      .reg_waddr(reg_waddr),
      .reg_wdata(reg_wdata),
      .iss_valid(iss_valid),
      .iss_waddr(iss_waddr),
      .flush    (flush),
      .rd_raddr (rd_raddr),
      .rd_rdata (rd_rdata),
      .rd_busy  (rd_busy),
      .busy_vec (busy_vec)
   );

   initial clk_reg = 1'b0;
   always #5 clk_reg = ~clk_reg;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_reg);
      #1;
   endtask

   task automatic idle();
      reg_wen = 1'b0; iss_valid = 1'b0; flush = 1'b0;
   endtask

   task automatic rd(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
      rd_raddr = {a1, a0};
      #1;
   endtask

   task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
      reg_wen = 1'b1; reg_waddr = a; reg_wdata = d;
      tick();
      idle();
   endtask

   task automatic iss(input logic [AW-1:0] a);
      iss_valid = 1'b1; iss_waddr = a;
      tick();
      idle();
   endtask

   initial begin
      rst_reg_n = 1'b0;
      idle();
      reg_waddr = '0; reg_wdata = '0; iss_waddr = '0;
      rd(16'h0004, 16'h007C);

      // Reset state, held and after release
      check("rst_rd0",   rd_rdata[0 +: DW], 0);
      check("rst_rd1",   rd_rdata[DW +: DW], 0);
      check("rst_busy",  busy_vec, 0);
      check("rst_rbusy", rd_busy, 0);
      tick(); tick();
      rst_reg_n = 1'b1;
      tick(); #1;
      check("rel_rd0",  rd_rdata[0 +: DW], 0);
      check("rel_busy", busy_vec, 0);

      // Write then read on both ports
      wr(16'h0004, 32'hDEADBEEF);
      rd(16'h0004, 16'h0004);
      check("wr_p0", rd_rdata[0 +: DW], 32'hDEADBEEF);
      check("wr_p1", rd_rdata[DW +: DW], 32'hDEADBEEF);
      wr(16'h0000, 32'h12345678);
      rd(16'h0000, 16'h0004);
      check("x0_zero", rd_rdata[0 +: DW], 0);

      // Scoreboard lifecycle
      iss(16'h0028);
      rd(16'h0004, 16'h0028);
      check("iss_vec",   busy_vec, 32'h0000_0400);
      check("iss_rbusy", rd_busy, 2'b10);
      wr(16'h0028, 32'h55);
      check("wb_vec",  busy_vec, 0);
      check("wb_data", rd_rdata[DW +: DW], 32'h55);

      // Issue beats same-cycle writeback
      iss(16'h0014);
      reg_wen = 1'b1; reg_waddr = 16'h0014; reg_wdata = 32'h77;
      iss_valid = 1'b1; iss_waddr = 16'h0014;
      tick(); idle();
      rd(16'h0014, 16'h0004);
      check("iss_wb_vec",  busy_vec, 32'h0000_0020);
      check("iss_wb_data", rd_rdata[0 +: DW], 32'h77);

      // Flush beats issue; write alongside flush still lands
      flush = 1'b1; iss_valid = 1'b1; iss_waddr = 16'h0018;
      reg_wen = 1'b1; reg_waddr = 16'h0008; reg_wdata = 32'h99;
      tick(); idle();
      rd(16'h0008, 16'h0018);
      check("flush_vec",  busy_vec, 0);
      check("flush_wr",   rd_rdata[0 +: DW], 32'h99);

      // Issue to x0 ignored
      iss(16'h0000);
      check("iss_x0", busy_vec, 0);

      // Boundary: top register
      wr(16'h007C, 32'h31313131);
      rd(16'h007C, 16'h0004);
      check("x31", rd_rdata[0 +: DW], 32'h31313131);

      // Invalid addresses: reads zero, not busy (x1 made busy first)
      iss(16'h0004);
      rd(16'h0080, 16'h0006);
      check("inv_rd0",   rd_rdata[0 +: DW], 0);
      check("inv_rd1",   rd_rdata[DW +: DW], 0);
      check("inv_rbusy", rd_busy, 2'b00);
      rd(16'h0084, 16'h0004);
      check("inv84_rd",  rd_rdata[0 +: DW], 0);
      check("x1_rbusy",  rd_busy, 2'b10);

      // Invalid writes and issues change nothing
      wr(16'h0080, 32'hFFFFFFFF);
      wr(16'h0084, 32'hFFFFFFFF);
      wr(16'h0006, 32'hFFFFFFFF);
      iss(16'h0086);
      rd(16'h0000, 16'h0004);
      check("invw_x0",  rd_rdata[0 +: DW], 0);
      check("invw_x1",  rd_rdata[DW +: DW], 32'hDEADBEEF);
      check("invi_vec", busy_vec, 32'h0000_0002);

      // Same-cycle write/read on port 1
      rd(16'h0004, 16'h0030);
      reg_wen = 1'b1; reg_waddr = 16'h0030; reg_wdata = 32'hA5A5A5A5;
      #1;
`ifdef REGS_RVSEED_BYPASS_EN
      check("byp_data", rd_rdata[DW +: DW], 32'hA5A5A5A5);
`else
      check("byp_data", rd_rdata[DW +: DW], 0);
`endif
      check("byp_busy", rd_busy[1], 0);
      tick(); idle();
      check("byp_after", rd_rdata[DW +: DW], 32'hA5A5A5A5);

      // Same-cycle write + issue on the read register
      reg_wen = 1'b1; reg_waddr = 16'h0030; reg_wdata = 32'h0BADF00D;
      iss_valid = 1'b1; iss_waddr = 16'h0030;
      #1;
`ifdef REGS_RVSEED_BYPASS_EN
      check("byp_iss_busy", rd_busy[1], 1);
      check("byp_iss_data", rd_rdata[DW +: DW], 32'h0BADF00D);
`else
      check("byp_iss_busy", rd_busy[1], 0);
      check("byp_iss_data", rd_rdata[DW +: DW], 32'hA5A5A5A5);
`endif
      tick(); idle();
      check("wiss_vec", busy_vec, 32'h0000_1002);
      check("wiss_data", rd_rdata[DW +: DW], 32'h0BADF00D);

      // Asynchronous reset mid-cycle
      #2;
      rst_reg_n = 1'b0;
      #1;
      check("arst_vec", busy_vec, 0);
      check("arst_rd0", rd_rdata[0 +: DW], 0);
      check("arst_rd1", rd_rdata[DW +: DW], 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
